uart_rx_frame_check: RTL and testbench
======================================

Name: uart_rx_frame_check

Overview:
Parametrised UART receive frame checker. It tracks frame position from per-bit sample strobes and checks the start bit (glitch), the optional parity bit and 1..N stop bits. It reports the received data word and per-frame error pulses, and keeps saturating error counters for status readback. It sits between the RX data sampler / edge counter and the RX FSM output stage, and replaces the single-purpose start-glitch flag.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9), LSB first.
STOP_BITS, 1, number of stop bits checked (1 or 2).
CNT_WIDTH, 8, width of each saturating error counter.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  reception enable; low aborts any frame in progress.
start_det  input  1  one-cycle pulse from the falling-edge detector; begins a frame.
bit_valid  input  1  one-cycle strobe; sampled_bit holds the mid-bit voted value.
sampled_bit  input  1  voted serial bit value.
par_en  input  1  parity enable; latched on accepted start_det.
par_typ  input  1  0 = even, 1 = odd; latched on accepted start_det.
err_clr  input  1  synchronous clear of all error counters.
rx_data  output  DATA_WIDTH  last good data word.
data_valid  output  1  one-cycle pulse when a frame completes with no error.
start_glitch  output  1  one-cycle pulse when the start bit is sampled high.
parity_err  output  1  one-cycle pulse on a parity mismatch.
stop_err  output  1  one-cycle pulse when any stop bit is sampled low.
busy  output  1  high from accepted start_det until the frame ends or aborts.
glitch_cnt  output  CNT_WIDTH  saturating count of start glitches.
parity_cnt  output  CNT_WIDTH  saturating count of parity errors.
stop_cnt  output  CNT_WIDTH  saturating count of stop errors.

Behaviour:
- Reset: all outputs are 0, and the FSM is in IDLE with internal shift register, bit counter and latched config cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on start_det && enable.
  - START -> DATA on bit_valid with sampled_bit = 0.
  - START -> IDLE on bit_valid with sampled_bit = 1; start_glitch pulses the next cycle.
  - DATA: shift in DATA_WIDTH bits LSB first; after the last bit go to PARITY if the latched par_en = 1, else go to STOP.
  - PARITY: store the sampled parity bit on bit_valid, then go to STOP.
  - STOP: count STOP_BITS strobes. On the last one go to IDLE and evaluate the frame.
- Expected parity: XOR of the data bits for even; XNOR for odd.
- Frame evaluation, registered one cycle after the last stop-bit strobe:
  - parity_err = par_en && mismatch.
  - stop_err = any stop bit was 0.
  - data_valid = neither error. rx_data updates in the same cycle as data_valid.
  - parity_err and stop_err may pulse together.
  - rx_data holds its previous value on an errored frame or an aborted frame.
- busy is asserted from the cycle after the accepted start_det until the cycle the FSM returns to IDLE.
- Ignored inputs:
  - start_det while not in IDLE.
  - bit_valid in IDLE.
  - par_en / par_typ changes mid-frame; the latched values are used.
- enable low in any non-IDLE state: the FSM goes to IDLE next cycle with no pulses and no counter change. In IDLE, enable low blocks start_det.
- Counters:
  - Each counter increments by 1 on its error pulse and saturates at 2^CNT_WIDTH-1.
  - err_clr zeroes all counters next cycle and wins over a simultaneous increment.
- Reset mid-frame: immediate return to the reset state; no pulses are emitted.

Test Plan:
- Good frame, DATA_WIDTH=8, par_en=1, par_typ=0: start 0, data 0xA5 LSB first, parity 0, stop 1 -> data_valid pulse one cycle after the stop strobe, rx_data=0xA5, all error flags 0, all counters 0, busy drops the same cycle.
- Start glitch: start_det then bit_valid with sampled_bit=1 -> start_glitch pulse, glitch_cnt=1, FSM back in IDLE, rx_data unchanged, a following good frame 0x3C is received correctly.
- Parity error: 0xA5 with even parity and parity bit 1 -> parity_err=1, data_valid=0, parity_cnt=1, rx_data keeps its old value; repeat with par_typ=1 and parity bit 1 -> data_valid, no error.
- STOP_BITS=2: first stop 1, second stop 0 -> stop_err pulse, stop_cnt=1; in a separate frame, bad parity plus bad stop -> parity_err and stop_err in the same cycle.
- CNT_WIDTH=2: five start glitches -> glitch_cnt=3 (saturated); err_clr asserted on the same cycle as a sixth glitch pulse -> glitch_cnt=0.
- Abort: enable dropped after the 4th data strobe -> IDLE next cycle, busy=0, no pulses, counters unchanged; rst_n asserted mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: follows frame position from per-bit strobes, checks
// start/parity/stop bits, reports good data words and keeps saturating error counters.
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  start_det,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  data_valid,
    output logic                  start_glitch,
    output logic                  parity_err,
    output logic                  stop_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  glitch_cnt,
    output logic [CNT_WIDTH-1:0]  parity_cnt,
    output logic [CNT_WIDTH-1:0]  stop_cnt
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BW-1:0]         bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bit_q;
    logic                  stop_bad_q;
    logic                  start_ok;
    logic                  glitch_ev;
    logic                  frame_end;
    logic                  par_bad;
    logic                  stop_bad;
    logic                  frame_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping enable mid-frame overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (state != IDLE && !enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_det && enable) state_nxt = START;
                START:   if (bit_valid) state_nxt = sampled_bit ? IDLE : DATA;
                DATA:    if (bit_valid && bit_cnt == LAST_DATA) state_nxt = par_en_q ? PARITY : STOP;
                PARITY:  if (bit_valid) state_nxt = STOP;
                STOP:    if (bit_valid && bit_cnt == LAST_STOP) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        start_ok   = (state == IDLE) && start_det && enable;
        glitch_ev  = (state == START) && enable && bit_valid && sampled_bit;
        frame_end  = (state == STOP) && enable && bit_valid && (bit_cnt == LAST_STOP);
        par_bad    = par_en_q && (par_bit_q != (^shift_q ^ par_typ_q));
        stop_bad   = stop_bad_q || !sampled_bit;
        frame_good = !par_bad && !stop_bad;
    end

    // bit_cnt is shared: data bit index, then stop bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else if (start_ok) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            par_bit_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else if (enable && bit_valid) begin
            case (state)
                DATA: begin
                    shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
                end
                PARITY: par_bit_q <= sampled_bit;
                STOP: begin
                    stop_bad_q <= stop_bad;
                    bit_cnt    <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            data_valid   <= 1'b0;
            start_glitch <= 1'b0;
            parity_err   <= 1'b0;
            stop_err     <= 1'b0;
        end else begin
            data_valid   <= frame_end && frame_good;
            start_glitch <= glitch_ev;
            parity_err   <= frame_end && par_bad;
            stop_err     <= frame_end && stop_bad;
            if (frame_end && frame_good) begin
                rx_data <= shift_q;
            end
        end
    end

    // Counters advance on the registered pulses, so a clear in the pulse cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
            parity_cnt <= '0;
            stop_cnt   <= '0;
        end else if (err_clr) begin
            glitch_cnt <= '0;
            parity_cnt <= '0;
            stop_cnt   <= '0;
        end else begin
            if (start_glitch && glitch_cnt != CNT_MAX) glitch_cnt <= glitch_cnt + 1'b1;
            if (parity_err && parity_cnt != CNT_MAX) parity_cnt <= parity_cnt + 1'b1;
            if (stop_err && stop_cnt != CNT_MAX) stop_cnt <= stop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Randomised bench for uart_rx_frame_check with a frame-level reference model;
// every cycle all outputs are compared against the model's expectations.
module tb_uart_rx_frame_check;

    localparam int DW   = 8;
    localparam int SB   = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          start_det;
    logic          bit_valid;
    logic          sampled_bit;
    logic          par_en;
    logic          par_typ;
    logic          err_clr;
    logic [DW-1:0] rx_data;
    logic          data_valid;
    logic          start_glitch;
    logic          parity_err;
    logic          stop_err;
    logic          busy;
    logic [CW-1:0] glitch_cnt;
    logic [CW-1:0] parity_cnt;
    logic [CW-1:0] stop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_rx;
    logic exp_busy, exp_dv, exp_sg, exp_pe, exp_se;
    logic cur_sg, cur_pe, cur_se;
    int   cnt_g, cnt_p, cnt_s;
    bit   rand_clr_en;

    always #5 clk = ~clk;

    uart_rx_frame_check #(.DATA_WIDTH(DW), .STOP_BITS(SB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start_det(start_det),
        .bit_valid(bit_valid), .sampled_bit(sampled_bit), .par_en(par_en),
        .par_typ(par_typ), .err_clr(err_clr), .rx_data(rx_data),
        .data_valid(data_valid), .start_glitch(start_glitch),
        .parity_err(parity_err), .stop_err(stop_err), .busy(busy),
        .glitch_cnt(glitch_cnt), .parity_cnt(parity_cnt), .stop_cnt(stop_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int satInc(input int c, input logic p);
        return (p && c < CMAX) ? c + 1 : c;
    endfunction

    task automatic checkAll();
        checkOutput("rx_data", 32'(rx_data), 32'(exp_rx));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("data_valid", 32'(data_valid), 32'(exp_dv));
        checkOutput("start_glitch", 32'(start_glitch), 32'(exp_sg));
        checkOutput("parity_err", 32'(parity_err), 32'(exp_pe));
        checkOutput("stop_err", 32'(stop_err), 32'(exp_se));
        checkOutput("glitch_cnt", 32'(glitch_cnt), 32'(cnt_g));
        checkOutput("parity_cnt", 32'(parity_cnt), 32'(cnt_p));
        checkOutput("stop_cnt", 32'(stop_cnt), 32'(cnt_s));
    endtask

    task automatic modelReset();
        exp_rx = '0; exp_busy = 0; exp_dv = 0; exp_sg = 0; exp_pe = 0; exp_se = 0;
        cur_sg = 0; cur_pe = 0; cur_se = 0;
        cnt_g = 0; cnt_p = 0; cnt_s = 0;
    endtask

    // Inputs and post-edge expectations are set by the caller before calling step.
    task automatic step();
        if (rand_clr_en && $urandom_range(0, 19) == 0) err_clr = 1'b1;
        if (err_clr) begin
            cnt_g = 0; cnt_p = 0; cnt_s = 0;
        end else begin
            cnt_g = satInc(cnt_g, cur_sg);
            cnt_p = satInc(cnt_p, cur_pe);
            cnt_s = satInc(cnt_s, cur_se);
        end
        @(negedge clk);
        cur_sg = exp_sg; cur_pe = exp_pe; cur_se = exp_se;
        checkAll();
        exp_dv = 0; exp_sg = 0; exp_pe = 0; exp_se = 0;
        start_det = 1'b0;
        bit_valid = 1'b0;
        err_clr = 1'b0;
        sampled_bit = 1'($urandom_range(0, 1));
    endtask

    task automatic idleGaps(input bit in_frame);
        int n = $urandom_range(0, 2);
        repeat (n) begin
            if (in_frame) start_det = 1'($urandom_range(0, 1));
            else bit_valid = 1'($urandom_range(0, 1));
            if (in_frame) begin
                par_en  = 1'($urandom_range(0, 1));
                par_typ = 1'($urandom_range(0, 1));
            end
            step();
        end
    endtask

    task automatic applyStimulus(input logic b);
        idleGaps(1);
        bit_valid = 1'b1;
        sampled_bit = b;
    endtask

    task automatic sendFrame(input logic [DW-1:0] data, input bit pe, input bit pt, input bit pbit,
                             input bit s0, input bit s1, input bit glitch, input int abort_at);
        bit want, par_bad, stop_bad;
        idleGaps(0);
        par_en = pe; par_typ = pt; start_det = 1'b1; exp_busy = 1; step();
        applyStimulus(glitch);
        if (glitch) begin
            exp_sg = 1; exp_busy = 0; step();
            return;
        end
        step();
        for (int i = 0; i < DW; i++) begin
            applyStimulus(data[i]);
            step();
            if (i + 1 == abort_at) begin
                enable = 1'b0; exp_busy = 0; step();
                enable = 1'b1;
                return;
            end
        end
        if (pe) begin
            applyStimulus(pbit);
            step();
        end
        applyStimulus(s0);
        step();
        applyStimulus(s1);
        want     = (($countones(data) + int'(pt)) % 2) == 1;
        par_bad  = pe && (pbit != want);
        stop_bad = !(s0 && s1);
        exp_pe = par_bad;
        exp_se = stop_bad;
        exp_dv = !par_bad && !stop_bad;
        if (exp_dv) exp_rx = data;
        exp_busy = 0;
        step();
    endtask

    task automatic blockedStart();
        enable = 1'b0; start_det = 1'b1; step();
        enable = 1'b1; bit_valid = 1'b1; step();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        bit pe, pt, pb, s0, s1, gl;
        int ab;

        rst_n = 1'b0; enable = 1'b1; start_det = 1'b0; bit_valid = 1'b0;
        sampled_bit = 1'b0; par_en = 1'b0; par_typ = 1'b0; err_clr = 1'b0;
        rand_clr_en = 0;
        modelReset();
        #12;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        sendFrame(8'hA5, 1, 0, 0, 1, 1, 0, 0);
        sendFrame(8'h00, 0, 0, 0, 1, 1, 1, 0);
        sendFrame(8'h3C, 1, 0, 0, 1, 1, 0, 0);
        sendFrame(8'hA5, 1, 0, 1, 1, 1, 0, 0);
        sendFrame(8'hA5, 1, 1, 1, 1, 1, 0, 0);
        sendFrame(8'h5A, 0, 0, 0, 1, 0, 0, 0);
        sendFrame(8'hA5, 1, 0, 1, 0, 1, 0, 0);
        sendFrame(8'h96, 0, 1, 0, 1, 1, 0, 4);
        step();
        blockedStart();

        for (int k = 0; k < 6; k++) sendFrame(8'h00, 0, 0, 0, 1, 1, 1, 0);
        err_clr = 1'b1;
        step();
        step();

        rand_clr_en = 1;
        for (int k = 0; k < 150; k++) begin
            d  = DW'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            pb = (((($countones(d) + int'(pt)) % 2) == 1)) ^ ($urandom_range(0, 3) == 0);
            s0 = ($urandom_range(0, 5) != 0);
            s1 = ($urandom_range(0, 5) != 0);
            gl = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, DW) : 0;
            if ($urandom_range(0, 9) == 0) blockedStart();
            else sendFrame(d, pe, pt, pb, s0, s1, gl, ab);
        end

        rand_clr_en = 0;
        sendFrame(8'hC3, 1, 0, 1, 1, 1, 0, 0);
        step();
        par_en = 1'b1; start_det = 1'b1; exp_busy = 1; step();
        bit_valid = 1'b1; sampled_bit = 1'b0; step();
        bit_valid = 1'b1; sampled_bit = 1'b1; step();
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        sendFrame(8'h3C, 0, 0, 0, 1, 1, 0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
